// File: rtl/wb_trace_buffer.sv
//----------------------------------------------------------------------------
// wb_trace_buffer
//
// Captures every committed register-file write reported by the CPU writeback
// debug trace as a {pc, wnum, wdata} record, buffers it in a show-ahead FIFO
// and drains it over a valid/ready stream. Writes to $0 are never recorded.
// When the FIFO is full and nothing is popped, the incoming record is dropped.
// Every drop sets a sticky overflow flag and bumps a saturating drop counter,
// so loss is never silent.
//
// Optional feature macro: TRACE_SEQ_EN
//   defined   - a 16-bit wrapping counter advances on every capture attempt,
//               including dropped ones. Each stored record carries the counter
//               value at its capture, so gaps in trace_seq reveal lost records.
//   undefined - no counter and no seq storage; trace_seq is tied to 0.
//
// Ports
//   clk, resetn          system clock (posedge); async active-low reset
//   trace_en             1 = capture enabled
//   debug_wb_pc          PC of the writing instruction
//   debug_wb_rf_wen      regfile write strobe
//   debug_wb_rf_wnum     destination register number
//   debug_wb_rf_wdata    value written
//   trace_valid          head record valid (== trace_count != 0)
//   trace_ready          consumer accepts head record
//   trace_pc/wnum/wdata  head record fields
//   trace_seq            head record sequence number (0 without TRACE_SEQ_EN)
//   trace_count          occupied entries (ADDR_W+1 bits)
//   overflow             sticky: at least one record dropped
//   drop_cnt             dropped records, saturating at 8'hFF
//----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              trace_en,
    input  logic [31:0]       debug_wb_pc,
    input  logic              debug_wb_rf_wen,
    input  logic [4:0]        debug_wb_rf_wnum,
    input  logic [31:0]       debug_wb_rf_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_wnum,
    output logic [31:0]       trace_wdata,
    output logic [15:0]       trace_seq,
    output logic [ADDR_W:0]   trace_count,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    rec_t              mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic push_req;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    assign push_req = trace_en & debug_wb_rf_wen & (debug_wb_rf_wnum != 5'd0);
    assign pop      = trace_valid & trace_ready;
    assign full     = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when the head is being consumed.
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({accept, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // while trace_valid=1, i.e. after a write, so resetting it would just
    // cost a reset net on every bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= '{pc:    debug_wb_pc,
                                 wnum:  debug_wb_rf_wnum,
                                 wdata: debug_wb_rf_wdata};
        end
    end

`ifdef TRACE_SEQ_EN
    logic [15:0] seq_q;
    logic [15:0] seq_mem_q [DEPTH];

    // Counts capture attempts, dropped ones included, so gaps are visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       seq_q <= '0;
        else if (push_req) seq_q <= seq_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) seq_mem_q[wr_ptr_q] <= seq_q;
    end

    assign trace_seq = seq_mem_q[rd_ptr_q];
`else
    assign trace_seq = 16'h0000;
`endif

    // Show-ahead: the head entry is presented directly from storage, so
    // back-to-back pops need no bubble.
    assign trace_valid = (count_q != '0);
    assign trace_pc    = mem_q[rd_ptr_q].pc;
    assign trace_wnum  = mem_q[rd_ptr_q].wnum;
    assign trace_wdata = mem_q[rd_ptr_q].wdata;
    assign trace_count = count_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
//----------------------------------------------------------------------------
// tb_wb_trace_buffer
//
// Self-checking bench for wb_trace_buffer (DEPTH=16). A reference queue holds
// every record the buffer should have accepted; head records are compared
// when the bench pops them. A short vector table covers single-record
// latency and the capture filter; hand-written sequences cover overflow,
// full push+pop, asynchronous reset mid-drain and a long random run.
// Honours TRACE_SEQ_EN the same way the design does.
//----------------------------------------------------------------------------
module tb_wb_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              resetn;
    logic              trace_en;
    logic [31:0]       debug_wb_pc;
    logic              debug_wb_rf_wen;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;
    logic              trace_valid;
    logic              trace_ready;
    logic [31:0]       trace_pc;
    logic [4:0]        trace_wnum;
    logic [31:0]       trace_wdata;
    logic [15:0]       trace_seq;
    logic [ADDR_W:0]   trace_count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    wb_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .trace_en          (trace_en),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .trace_seq         (trace_seq),
        .trace_count       (trace_count),
        .overflow          (overflow),
        .drop_cnt          (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [15:0] seq;
    } rec_t;

    typedef struct {
        logic        en;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_valid;
        int          exp_count;
    } vec_t;

    rec_t        sb_q[$];
    logic [15:0] m_seq;
    logic        m_overflow;
    logic [7:0]  m_drop;
    int          total;
    int          bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_seq(input logic [15:0] s);
`ifdef TRACE_SEQ_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_seq      = '0;
        m_overflow = 1'b0;
        m_drop     = '0;
    endtask

    // Drive one cycle: inputs applied just after a posedge, outputs compared
    // on the negedge, reference model advanced for the coming posedge.
    task automatic step(input logic en, input logic wen, input logic [4:0] wnum,
                        input logic [31:0] pc, input logic [31:0] wdata,
                        input logic ready);
        logic m_push;
        logic m_pop;
        rec_t r;
        trace_en          = en;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_pc       = pc;
        debug_wb_rf_wdata = wdata;
        trace_ready       = ready;
        @(negedge clk);
        check("valid", 64'(trace_valid), 64'(sb_q.size() != 0));
        check("count", 64'(trace_count), 64'(sb_q.size()));
        check("overflow", 64'(overflow), 64'(m_overflow));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        m_push = en & wen & (wnum != 5'd0);
        m_pop  = (sb_q.size() != 0) & ready;
        if (m_pop) begin
            r = sb_q.pop_front();
            check("head_pc", 64'(trace_pc), 64'(r.pc));
            check("head_wnum", 64'(trace_wnum), 64'(r.wnum));
            check("head_wdata", 64'(trace_wdata), 64'(r.wdata));
            check("head_seq", 64'(trace_seq), 64'(exp_seq(r.seq)));
        end
        if (m_push) begin
            if (sb_q.size() < DEPTH) begin
                sb_q.push_back('{pc: pc, wnum: wnum, wdata: wdata, seq: m_seq});
            end else begin
                m_overflow = 1'b1;
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end
            m_seq = m_seq + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        total = 0;
        bad   = 0;
        resetn            = 1'b0;
        trace_en          = 1'b0;
        debug_wb_rf_wen   = 1'b0;
        debug_wb_rf_wnum  = '0;
        debug_wb_pc       = '0;
        debug_wb_rf_wdata = '0;
        trace_ready       = 1'b0;
        model_reset();

        // en wen wnum pc wdata ready -> valid/count after the edge
        vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hBFC00000, 32'h1234, 1'b1, 1'b1, 1};
        vecs[1] = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    1'b1, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b1, 5'd0, 32'h100,      32'hAAAA, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 5'd7, 32'h104,      32'hBBBB, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b0, 5'd7, 32'h108,      32'hCCCC, 1'b0, 1'b0, 0};

        // Reset state
        @(posedge clk);
        #1;
        check("rst_valid", 64'(trace_valid), 64'(0));
        check("rst_count", 64'(trace_count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));
        resetn = 1'b1;

        // Single-record latency and capture filter
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].en, vecs[i].wen, vecs[i].wnum, vecs[i].pc, vecs[i].wdata, vecs[i].ready);
            check($sformatf("vec%0d_valid", i), 64'(trace_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 64'(trace_count), 64'(vecs[i].exp_count));
            if (i == 0) begin
                check("vec0_pc", 64'(trace_pc), 64'h0BFC00000);
                check("vec0_wnum", 64'(trace_wnum), 64'd5);
                check("vec0_wdata", 64'(trace_wdata), 64'h1234);
            end
        end

        // Overflow: 20 pushes with ready=0, then drain
        do_reset();
        for (int i = 1; i <= 20; i++)
            step(1'b1, 1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(4 * i), 32'(i), 1'b0);
        check("ovf_count", 64'(trace_count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd4);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
            check("drain_no_bubble", 64'(trace_valid), 64'd1);
        end
        check("last_head_wdata", 64'(trace_wdata), 64'd16);
        check("last_head_seq", 64'(trace_seq), 64'(exp_seq(16'd15)));
        // Final pop together with a fresh push (seq 20 after 20 attempts)
        step(1'b1, 1'b1, 5'd9, 32'h2000, 32'hDEAD0020, 1'b1);
        check("next_wdata", 64'(trace_wdata), 64'hDEAD0020);
        check("next_seq", 64'(trace_seq), 64'(exp_seq(16'd20)));

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b1, 5'd3, 32'h3000 + 32'(4 * i), 32'h300 + 32'(i), 1'b0);
        check("full_count", 64'(trace_count), 64'd16);
        step(1'b1, 1'b1, 5'd4, 32'h4000, 32'hFEEDF00D, 1'b1);
        check("pp_count", 64'(trace_count), 64'd16);
        check("pp_drop", 64'(drop_cnt), 64'd4);
        check("pp_last", 64'(sb_q[DEPTH-1].wdata), 64'hFEEDF00D);

        // Async reset mid-drain with 8 records left
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("pre_rst_count", 64'(trace_count), 64'd8);
        trace_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(trace_valid), 64'd0);
        check("arst_count", 64'(trace_count), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Random traffic against the reference queue
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 31)), $urandom, $urandom,
                 ($urandom_range(0, 9) < 3));
            if (trace_count > (ADDR_W + 1)'(DEPTH)) begin
                check("count_bound", 64'(trace_count), 64'(DEPTH));
            end
        end
        check("drop_saturated", 64'(drop_cnt), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
